// File: rtl/flag_fifo.sv
// flag_fifo: single-clock FIFO with registered read data and registered status flags.
// The occupancy flags (empty, almostfull, full) come from the next occupancy value,
// so they change on the same clock edge as count.
// Optional feature macro: FLAG_FIFO_ERR_EN adds the sticky overflow and underflow outputs.
module flag_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned AFULL_LEVEL = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              empty,
  output logic              almostfull,
  output logic              full,
`ifdef FLAG_FIFO_ERR_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [ADDR_W:0]   count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              full_q, full_d;
  logic              wr_ok, rd_ok;

  // Accept strobes against the flags registered before this edge.
  assign wr_ok = wr & ~full_q;
  assign rd_ok = rd & ~empty_q;

  // Next pointers, occupancy, read data and flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    if (wr_ok) begin
      wptr_d = wptr_q + ADDR_W'(1);
    end
    if (rd_ok) begin
      rptr_d  = rptr_q + ADDR_W'(1);
      dout_d  = mem_q[rptr_q];
      valid_d = 1'b1;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
    afull_d = (count_d >= CNT_W'(AFULL_LEVEL));
  end

  // Control and status registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
      full_q  <= full_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem_q[wptr_q] <= din;
    end
  end

`ifdef FLAG_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error bits: set on a rejected strobe, cleared only by reset.
  always_comb begin
    ovf_d = ovf_q | (wr & full_q);
    unf_d = unf_q | (rd & empty_q);
  end

  // Error bit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

  assign dout       = dout_q;
  assign valid      = valid_q;
  assign empty      = empty_q;
  assign almostfull = afull_q;
  assign full       = full_q;
  assign count      = count_q;

endmodule

// File: tb/tb_flag_fifo.sv
// tb_flag_fifo: scoreboard bench for flag_fifo. A queue models the FIFO contents;
// every accepted read pushes its expected word to exp_q, popped when valid rises.
module tb_flag_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic [7:0] din;
  logic       rd;
  logic [7:0] dout;
  logic       valid;
  logic       empty;
  logic       almostfull;
  logic       full;
  logic [4:0] count;
`ifdef FLAG_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  logic       exp_valid;
  logic       exp_ovf;
  logic       exp_unf;
  logic       wok;
  logic       rok;
  logic [7:0] got;

  flag_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_LEVEL(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr),
    .din        (din),
    .rd         (rd),
    .dout       (dout),
    .valid      (valid),
    .empty      (empty),
    .almostfull (almostfull),
    .full       (full),
`ifdef FLAG_FIFO_ERR_EN
    .overflow   (overflow),
    .underflow  (underflow),
`endif
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one cycle of strobes and advance the reference model on the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    wr  = w;
    din = d;
    rd  = r;
    @(posedge clk);
    wok = w && (model.size() < 16);
    rok = r && (model.size() != 0);
    if (w && model.size() == 16) exp_ovf = 1'b1;
    if (r && model.size() == 0) exp_unf = 1'b1;
    if (rok) exp_q.push_back(model.pop_front());
    if (wok) model.push_back(d);
    exp_valid = rok;
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    repeat (cycles) @(posedge clk);
    model.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset(2);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almostfull !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almostfull); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      checks++; if (almostfull !== (i >= 14)) begin errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almostfull, (i >= 14)); end
      checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 16)); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
    end
    step(1'b1, 8'hAA, 1'b0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL overfill_count got=%0d exp=16", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL overfill_full got=%b exp=1", full); end
`ifdef FLAG_FIFO_ERR_EN
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL overflow got=%b exp=%b", overflow, exp_ovf); end
`endif
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      checks++; if (valid !== exp_valid) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=%b", i, valid, exp_valid); end
      if (valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL drain_unexpected[%0d] got=%h exp=none", i, dout); end
        else begin
          got = exp_q.pop_front();
          if (dout !== got) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, dout, got); end
        end
      end
      checks++; if (count !== 5'(15 - i)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 15 - i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
    step(1'b0, 8'h00, 1'b1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL underrd_valid got=%b exp=0", valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL underrd_count got=%0d exp=0", count); end
`ifdef FLAG_FIFO_ERR_EN
    checks++; if (underflow !== exp_unf) begin errors++; $display("FAIL underflow got=%b exp=%b", underflow, exp_unf); end
`endif
  endtask

  task automatic test_wrap;
    logic [7:0] wdata[$];
    for (int i = 0; i < 10; i++) wdata.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) wdata.push_back(8'hFF);
    for (int i = 0; i < 12; i++) wdata.push_back(8'h20 + 8'(i));
    for (int i = 0; i < 12; i++) wdata.push_back(8'hFF);
    // Entries of 0xFF in the table mean "read one word" rather than "write".
    for (int i = 0; i < wdata.size(); i++) begin
      if (wdata[i] == 8'hFF) step(1'b0, 8'h00, 1'b1);
      else step(1'b1, wdata[i], 1'b0);
      checks++; if (valid !== exp_valid) begin errors++; $display("FAIL wrap_valid[%0d] got=%b exp=%b", i, valid, exp_valid); end
      if (valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_unexpected[%0d] got=%h exp=none", i, dout); end
        else begin
          got = exp_q.pop_front();
          if (dout !== got) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, dout, got); end
        end
      end
      checks++; if (count !== 5'(model.size())) begin errors++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", i, count, model.size()); end
    end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_final_count got=%0d exp=0", count); end
  endtask

  task automatic test_simultaneous;
    step(1'b1, 8'h55, 1'b1);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL sim_empty_count got=%0d exp=1", count); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sim_empty_valid got=%b exp=0", valid); end
    for (int i = 0; i < 15; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL sim_prefull_count got=%0d exp=16", count); end
    step(1'b1, 8'hEE, 1'b1);
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL sim_full_count got=%0d exp=15", count); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sim_full_valid got=%b exp=1", valid); end
    checks++; if (dout !== 8'h55) begin errors++; $display("FAIL sim_full_data got=%h exp=55", dout); end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (valid === 1'b1 && exp_q.size() != 0) begin
        got = exp_q.pop_front();
        checks++; if (dout !== got) begin errors++; $display("FAIL sim_mid_data[%0d] got=%h exp=%h", i, dout, got); end
      end
    end
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL sim_five_pre got=%0d exp=5", count); end
    step(1'b1, 8'h99, 1'b1);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL sim_five_count got=%0d exp=5", count); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sim_five_valid got=%b exp=1", valid); end
    // Drain the rest; the rejected 0xEE must never appear and 0x99 must come out last.
    while (model.size() != 0 || exp_q.size() != 0) begin
      if (exp_q.size() != 0 && valid === 1'b1) begin
        got = exp_q.pop_front();
        checks++; if (dout !== got) begin errors++; $display("FAIL sim_tail_data got=%h exp=%h", dout, got); end
      end
      if (model.size() == 0) break;
      step(1'b0, 8'h00, 1'b1);
    end
    if (valid === 1'b1 && exp_q.size() != 0) begin
      got = exp_q.pop_front();
      checks++; if (dout !== got) begin errors++; $display("FAIL sim_last_data got=%h exp=%h", dout, got); end
    end
    checks++; if (dout !== 8'h99) begin errors++; $display("FAIL sim_last_word got=%h exp=99", dout); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sim_end_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 7; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL mid_pre_count got=%0d exp=7", count); end
    step(1'b0, 8'h00, 1'b1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    apply_reset(1);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", valid); end
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_rd_valid got=%b exp=1", valid); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL mid_rd_data got=%h exp=none", dout); end
    else begin
      got = exp_q.pop_front();
      if (dout !== got || dout !== 8'h77) begin errors++; $display("FAIL mid_rd_data got=%h exp=%h", dout, got); end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    wr        = 1'b0;
    rd        = 1'b0;
    din       = 8'h00;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    step(1'b0, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
